// File: rtl/signal_burst_gate_if.sv
// Bundle for signal_burst_gate: divider taps, burst configuration, start/stop
// handshake and the gated output with its status flags.
interface signal_burst_gate_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       tap_in;
    logic [2:0]       tap_sel;
    logic [CNT_W-1:0] burst_len;
    logic [CNT_W-1:0] gap_len;
    logic             cont;
    logic             start;
    logic             stop;
    logic             sig_out;
    logic             busy;
    logic             done;

    modport master (
        output tap_in, tap_sel, burst_len, gap_len, cont, start, stop,
        input  sig_out, busy, done
    );

    modport slave (
        input  tap_in, tap_sel, burst_len, gap_len, cont, start, stop,
        output sig_out, busy, done
    );
endinterface

// File: rtl/signal_burst_gate.sv
// Selects one divider tap and gates it out as bursts of whole periods, one-shot or repeating.
// Define BURST_SYNC_STAGE_EN to add one register stage on tap_in (tap-to-output latency 3).
module signal_burst_gate #(
    parameter int CNT_W = 8
) (
    input logic                clk,
    input logic                reset,
    signal_burst_gate_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [1:0]       state;
    logic [7:0]       tap_src;
    logic [7:0]       tap_p0;
    logic [7:0]       tap_p1;
    logic [2:0]       sel_l;
    logic [CNT_W-1:0] blen_l;
    logic [CNT_W-1:0] glen_l;
    logic             cont_l;
    logic [CNT_W-1:0] bcnt;
    logic [CNT_W-1:0] gcnt;
    logic             sig_q;
    logic             done_q;
    logic             s;
    logic             s_prev;
    logic             rise;
    logic             fall;
    logic             accept;

    // Compare at CNT_W+1 bits so a length of all-ones still terminates.
    function automatic logic burst_last(input logic [CNT_W-1:0] cnt,
                                        input logic [CNT_W-1:0] len);
        logic [CNT_W:0] next_cnt;
        next_cnt = {1'b0, cnt} + (CNT_W+1)'(1);
        return next_cnt == {1'b0, len};
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
        return cnt + CNT_W'(1);
    endfunction

`ifdef BURST_SYNC_STAGE_EN
    logic [7:0] tap_sync;

    // Extra input stage
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_sync <= '0;
        end else begin
            tap_sync <= bus.tap_in;
        end
    end

    assign tap_src = tap_sync;
`else
    assign tap_src = bus.tap_in;
`endif

    // Stage p0/p1: tap history for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_p0 <= '0;
            tap_p1 <= '0;
        end else begin
            tap_p0 <= tap_src;
            tap_p1 <= tap_p0;
        end
    end

    assign s      = tap_p0[sel_l];
    assign s_prev = tap_p1[sel_l];
    assign rise   = s & ~s_prev;
    assign fall   = ~s & s_prev;
    assign accept = bus.start & ~bus.stop & (state == ST_IDLE) & (bus.burst_len != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_l  <= '0;
            blen_l <= '0;
            glen_l <= '0;
            cont_l <= 1'b0;
        end else if (accept) begin
            sel_l  <= bus.tap_sel;
            blen_l <= bus.burst_len;
            glen_l <= bus.gap_len;
            cont_l <= bus.cont;
        end
    end

    // Output stage: state, counters, registered sig_out and done
    always_ff @(posedge clk) begin
        if (reset || bus.stop) begin
            state  <= ST_IDLE;
            sig_q  <= 1'b0;
            done_q <= 1'b0;
            bcnt   <= '0;
            gcnt   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sig_q <= 1'b0;
                    if (bus.start) begin
                        if (bus.burst_len == '0) begin
                            // Guard keeps zero-length requests from producing back-to-back pulses.
                            done_q <= ~done_q;
                        end else begin
                            state <= ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    sig_q <= 1'b0;
                    if (rise) begin
                        state <= ST_BURST;
                        sig_q <= 1'b1;
                        bcnt  <= '0;
                    end
                end
                ST_BURST: begin
                    sig_q <= s;
                    if (fall) begin
                        if (burst_last(bcnt, blen_l)) begin
                            done_q <= 1'b1;
                            bcnt   <= '0;
                            gcnt   <= '0;
                            state  <= cont_l ? ST_GAP : ST_IDLE;
                        end else begin
                            bcnt <= cnt_inc(bcnt);
                        end
                    end
                end
                ST_GAP: begin
                    sig_q <= 1'b0;
                    if (rise) begin
                        if (gcnt == glen_l) begin
                            state <= ST_BURST;
                            sig_q <= 1'b1;
                            gcnt  <= '0;
                        end else begin
                            gcnt <= cnt_inc(gcnt);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    sig_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sig_out = sig_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state != ST_IDLE);
endmodule

// File: tb/tb_signal_burst_gate.sv
// Bench for signal_burst_gate: directed and randomized bursts checked every cycle
// against an arithmetic model of the expected burst windows.
module tb_signal_burst_gate;
`ifdef BURST_SYNC_STAGE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk;
    logic reset;
    signal_burst_gate_if #(.CNT_W(8)) bus ();

    signal_burst_gate #(.CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model of the one outstanding request
    bit m_act  = 1'b0;
    bit m_zero = 1'b0;
    bit m_cont = 1'b0;
    int m_t0   = 0;
    int m_sel  = 0;
    int m_blen = 0;
    int m_glen = 0;
    int m_stop = -1;

    int  rises     = 0;
    int  dones     = 0;
    bit  prev_sig  = 1'b0;
    bit  gap_chk   = 1'b0;
    int  last_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp_v);
        end
    endtask

    // Tap value during cycle k is bit n of k; the selected tap reaches sig_out LAT cycles later,
    // so sig_out-domain rises are at cycles u with (u-LAT) mod 2P == P/2 style phase.
    function automatic int first_rise();
        int p;
        int h;
        int r;
        p = 1 << (m_sel + 1);
        h = 1 << m_sel;
        r = (m_t0 + 2 - LAT) % p;
        return m_t0 + 2 + ((h - r + p) % p);
    endfunction

    function automatic void model(input int u, output bit e_sig, output bit e_busy, output bit e_done);
        int p, h, ur, end0, v, c, w;
        e_sig  = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (!m_act) return;
        if (m_stop >= 0 && u > m_stop) return;
        if (m_zero) begin
            e_done = (u == m_t0 + 1);
            return;
        end
        if (u < m_t0 + 1) return;
        p    = 1 << (m_sel + 1);
        h    = 1 << m_sel;
        ur   = first_rise();
        end0 = ur + (m_blen - 1) * p + h;
        e_busy = m_cont || (u < end0);
        if (u < ur) return;
        v = u - ur;
        c = (m_blen + m_glen) * p;
        if (!m_cont && v >= c) return;
        w = v % c;
        e_sig  = (w < m_blen * p) && ((w % p) < h);
        e_done = (w == (m_blen - 1) * p + h);
    endfunction

    task automatic tick();
        bit es, eb, ed;
        @(posedge clk);
        cyc++;
        #1;
        bus.tap_in = cyc[7:0];
        model(cyc, es, eb, ed);
        chk("sig_out", bus.sig_out, es);
        chk("busy", bus.busy, eb);
        chk("done", bus.done, ed);
        if (bus.sig_out && !prev_sig) rises++;
        prev_sig = bus.sig_out;
        if (bus.done) begin
            dones++;
            if (gap_chk && last_done > 0) chk("done_period", cyc - last_done, 6);
            last_done = cyc;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        rises     = 0;
        dones     = 0;
        last_done = 0;
    endtask

    task automatic start_cmd(input int sel, input int blen, input int glen, input bit cnt,
                             input bit with_stop);
        bit es, eb, ed;
        bus.tap_sel   = sel[2:0];
        bus.burst_len = blen[7:0];
        bus.gap_len   = glen[7:0];
        bus.cont      = cnt;
        bus.start     = 1'b1;
        bus.stop      = with_stop;
        model(cyc, es, eb, ed);
        if (with_stop) begin
            if (m_act && m_stop < 0) m_stop = cyc;
        end else if (!eb) begin
            m_act  = 1'b1;
            m_zero = (blen == 0);
            m_t0   = cyc;
            m_sel  = sel;
            m_blen = blen;
            m_glen = glen;
            m_cont = cnt;
            m_stop = -1;
        end
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic stop_cmd();
        bus.stop = 1'b1;
        if (m_act && m_stop < 0) m_stop = cyc;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic reset_cmd();
        reset = 1'b1;
        if (m_act && m_stop < 0) m_stop = cyc;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int stop_at;
        int sel, blen, glen, n;
        bit cnt;
        reset         = 1'b1;
        bus.tap_in    = '0;
        bus.tap_sel   = '0;
        bus.burst_len = '0;
        bus.gap_len   = '0;
        bus.cont      = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;

        // reset held two cycles with taps toggling, then idle
        ticks(2);
        reset = 1'b0;
        ticks(6);

        // one-shot: tap 2, three periods
        clear_counts();
        start_cmd(2, 3, 0, 1'b0, 1'b0);
        ticks(40);
        chk("oneshot_pulses", rises, 3);
        chk("oneshot_dones", dones, 1);

        // continuous: tap 0, 2 pulses + 1 skipped period
        clear_counts();
        gap_chk = 1'b1;
        start_cmd(0, 2, 1, 1'b1, 1'b0);
        ticks(40);
        gap_chk = 1'b0;
        chk("cont_dones", dones >= 6, 1);
        stop_cmd();
        ticks(6);

        // zero length
        clear_counts();
        start_cmd(3, 0, 2, 1'b0, 1'b0);
        ticks(6);
        chk("zero_dones", dones, 1);
        chk("zero_pulses", rises, 0);

        // abort after second of five pulses
        clear_counts();
        start_cmd(2, 5, 0, 1'b0, 1'b0);
        stop_at = first_rise() + 8 + 4;
        while (cyc < stop_at) tick();
        stop_cmd();
        ticks(20);
        chk("abort_pulses", rises, 2);
        chk("abort_dones", dones, 0);

        // start and stop together in idle
        clear_counts();
        start_cmd(1, 3, 0, 1'b1, 1'b1);
        ticks(12);
        chk("collide_pulses", rises, 0);

        // start while busy is dropped
        clear_counts();
        start_cmd(1, 4, 0, 1'b0, 1'b0);
        ticks(2);
        start_cmd(0, 1, 0, 1'b1, 1'b0);
        ticks(40);
        chk("busy_start_pulses", rises, 4);
        chk("busy_start_dones", dones, 1);

        // maximum burst length
        clear_counts();
        start_cmd(0, 255, 0, 1'b0, 1'b0);
        ticks(520);
        chk("max_len_pulses", rises, 255);
        chk("max_len_dones", dones, 1);

        // randomized requests
        for (int i = 0; i < 12; i++) begin
            sel  = int'($urandom_range(0, 3));
            blen = int'($urandom_range(0, 4));
            glen = int'($urandom_range(0, 3));
            cnt  = 1'($urandom_range(0, 1));
            n    = int'($urandom_range(20, 150));
            start_cmd(sel, blen, glen, cnt, 1'b0);
            ticks(3);
            if ($urandom_range(0, 1) == 1) start_cmd(int'($urandom_range(0, 3)), 2, 0, 1'b0, 1'b0);
            ticks(n);
            stop_cmd();
            ticks(8);
        end

        // reset in the middle of a repeating burst
        start_cmd(1, 3, 1, 1'b1, 1'b0);
        ticks(20);
        reset_cmd();
        ticks(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
